// File: rtl/smart_home_pkg.sv
// Shared constants and state encodings for the smart-home input and lighting blocks.
package smart_home_pkg;

   localparam int CLK_FREQ_HZ_DEF = 50_000_000;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_CONFIRM_ON  = 2'd1,
      ST_ACTIVE      = 2'd2,
      ST_CONFIRM_OFF = 2'd3
   } ch_state_e;

   typedef enum logic {
      ST_WARMUP = 1'b0,
      ST_RUN    = 1'b1
   } top_state_e;

endpackage

// File: rtl/pir_debounce_channel.sv
// One PIR channel: 2-flop synchroniser, debounce FSM and saturating event counter.
// state          | meaning
// ST_IDLE        | clean inactive, waiting for the sensor to go active
// ST_CONFIRM_ON  | sensor active, counting stable cycles before asserting clean
// ST_ACTIVE      | clean active, waiting for the sensor to go inactive
// ST_CONFIRM_OFF | sensor inactive, counting stable cycles before releasing clean
module pir_debounce_channel
   import smart_home_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int EVT_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             pir_raw,
   input  logic             clear_counts,
   output logic             pir_clean,
   output logic             pir_rise,
   output logic [EVT_W-1:0] event_cnt
);

   localparam int                DB_W    = $clog2(DB_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [EVT_W-1:0]  EVT_MAX = '1;

   logic [1:0]       sync_q;
   logic             act_n;
   ch_state_e        state_q;
   logic [DB_W-1:0]  db_cnt_q;
   logic             clean_q;
   logic             rise_q;
   logic [EVT_W-1:0] evt_q;

   // Parked at idle until RUN, so a sensor already active at warm-up end is
   // treated as a fresh edge and gets the full activation latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     sync_q <= 2'b11;
      else if (!enable) sync_q <= 2'b11;
      else              sync_q <= {sync_q[0], pir_raw};
   end

   assign act_n = ~sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         db_cnt_q <= '0;
         clean_q  <= 1'b1;
         rise_q   <= 1'b0;
      end else if (!enable) begin
         state_q  <= ST_IDLE;
         db_cnt_q <= '0;
         clean_q  <= 1'b1;
         rise_q   <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (act_n) begin
                  state_q  <= ST_CONFIRM_ON;
                  db_cnt_q <= DB_W'(1);
               end
            end
            ST_CONFIRM_ON: begin
               if (!act_n) begin
                  state_q  <= ST_IDLE;
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q  <= ST_ACTIVE;
                  db_cnt_q <= '0;
                  clean_q  <= 1'b0;
                  rise_q   <= 1'b1;
               end else begin
                  db_cnt_q <= db_cnt_q + DB_W'(1);
               end
            end
            ST_ACTIVE: begin
               if (!act_n) begin
                  state_q  <= ST_CONFIRM_OFF;
                  db_cnt_q <= DB_W'(1);
               end
            end
            ST_CONFIRM_OFF: begin
               if (act_n) begin
                  state_q  <= ST_ACTIVE;
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q  <= ST_IDLE;
                  db_cnt_q <= '0;
                  clean_q  <= 1'b1;
               end else begin
                  db_cnt_q <= db_cnt_q + DB_W'(1);
               end
            end
         endcase
      end
   end

   // A clear coinciding with a pulse keeps that event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        evt_q <= '0;
      else if (clear_counts)               evt_q <= EVT_W'(rise_q);
      else if (rise_q && evt_q != EVT_MAX) evt_q <= evt_q + EVT_W'(1);
   end

   assign pir_clean = clean_q;
   assign pir_rise  = rise_q;
   assign event_cnt = evt_q;

endmodule

// File: rtl/pir_conditioner.sv
// Two-channel PIR input conditioner: warm-up lockout after reset, then two
// independent debounce channels feeding the lights block and status logic.
module pir_conditioner
   import smart_home_pkg::*;
#(
   parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
   parameter int DEBOUNCE_MS = 20,
   parameter int WARMUP_SEC  = 2,
   parameter int EVT_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pir_raw_1,
   input  logic             pir_raw_2,
   input  logic             clear_counts,
   output logic             pir_clean_1,
   output logic             pir_clean_2,
   output logic             pir_rise_1,
   output logic             pir_rise_2,
   output logic             warmup_done,
   output logic [EVT_W-1:0] event_cnt_1,
   output logic [EVT_W-1:0] event_cnt_2
);

   localparam int              DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
   localparam int              WU_CYCLES = CLK_FREQ_HZ * WARMUP_SEC;
   localparam int              WU_W      = (WU_CYCLES > 1) ? $clog2(WU_CYCLES) : 1;
   localparam logic [WU_W-1:0] WU_LAST   = WU_W'(WU_CYCLES - 1);

   top_state_e      top_q;
   logic [WU_W-1:0] wu_cnt_q;
   logic            warmup_done_q;
   logic            ch_enable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         top_q         <= ST_WARMUP;
         wu_cnt_q      <= '0;
         warmup_done_q <= 1'b0;
      end else begin
         unique case (top_q)
            ST_WARMUP: begin
               if (wu_cnt_q == WU_LAST) begin
                  top_q         <= ST_RUN;
                  warmup_done_q <= 1'b1;
               end else begin
                  wu_cnt_q <= wu_cnt_q + WU_W'(1);
               end
            end
            ST_RUN: top_q <= ST_RUN;
         endcase
      end
   end

   assign ch_enable   = (top_q == ST_RUN);
   assign warmup_done = warmup_done_q;

   pir_debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .EVT_W     (EVT_W)
   ) u_ch1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (ch_enable),
      .pir_raw      (pir_raw_1),
      .clear_counts (clear_counts),
      .pir_clean    (pir_clean_1),
      .pir_rise     (pir_rise_1),
      .event_cnt    (event_cnt_1)
   );

   pir_debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .EVT_W     (EVT_W)
   ) u_ch2 (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (ch_enable),
      .pir_raw      (pir_raw_2),
      .clear_counts (clear_counts),
      .pir_clean    (pir_clean_2),
      .pir_rise     (pir_rise_2),
      .event_cnt    (event_cnt_2)
   );

endmodule
